// File: rtl/rom_dl_seq.sv
// ROM download sequencer: source byte stream -> 4-deep FIFO -> paced write strobes.
// Ports: DLCL/RST_N, START, SDT/SVL/SRD source side, DLAD/DLDT/DLEN write side, BUSY/DONE/OVF/CSUM status.
module rom_dl_seq #(
  parameter logic [17:0] LEN = 18'h24020,
  parameter int          GAP = 0
) (
  input  logic        DLCL,
  input  logic        RST_N,
  input  logic        START,
  input  logic [7:0]  SDT,
  input  logic        SVL,
  output logic        SRD,
  output logic [17:0] DLAD,
  output logic [7:0]  DLDT,
  output logic        DLEN,
  output logic        BUSY,
  output logic        DONE,
  output logic        OVF,
  output logic [15:0] CSUM
);

  localparam logic [3:0] GV = 4'(GAP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } st_t;

  st_t st, st_n;

  logic [7:0]  mem [4];
  logic [1:0]  wp, rp;
  logic [2:0]  cnt;
  logic [17:0] acc, wa;
  logic [3:0]  gap;
  logic        push, pop, last;

  always_comb begin
    st_n = st;
    SRD  = 1'b0;
    BUSY = 1'b0;
    DONE = 1'b0;
    push = 1'b0;
    pop  = 1'b0;
    last = 1'b0;
    unique case (st)
      S_LOAD: begin
        BUSY = 1'b1;
        SRD  = (cnt < 3'd4) && (acc < LEN);
        push = SVL && SRD;
        pop  = (cnt != 3'd0) && (gap == 4'd0);
        last = pop && (wa == LEN - 18'd1);
        if (last)
          st_n = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        SRD  = 1'b1;
      end
      default: ;
    endcase
    if (START)
      st_n = S_LOAD;
  end

  // FIFO storage is plain datapath; occupancy is tracked below.
  always_ff @(posedge DLCL) begin
    if (push)
      mem[wp] <= SDT;
  end

  always_ff @(posedge DLCL or negedge RST_N) begin
    if (!RST_N) begin
      st   <= S_IDLE;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      acc  <= '0;
      wa   <= '0;
      gap  <= '0;
      DLAD <= '0;
      DLDT <= '0;
      DLEN <= 1'b0;
      OVF  <= 1'b0;
      CSUM <= '0;
    end else if (START) begin
      st   <= st_n;
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      acc  <= '0;
      wa   <= '0;
      gap  <= '0;
      DLEN <= 1'b0;
      OVF  <= 1'b0;
      CSUM <= '0;
    end else begin
      st   <= st_n;
      DLEN <= pop;
      if (push) begin
        wp  <= wp + 2'd1;
        acc <= acc + 18'd1;
      end
      if (pop) begin
        rp   <= rp + 2'd1;
        DLAD <= wa;
        DLDT <= mem[rp];
        CSUM <= CSUM + {8'd0, mem[rp]};
        gap  <= GV;
        // Address parks on LEN-1 after the final strobe.
        if (!last)
          wa <= wa + 18'd1;
      end else if (gap != 4'd0) begin
        gap <= gap - 4'd1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: ;
      endcase
      // Anything taken after completion is dropped but flagged.
      if (st == S_DONE && SVL)
        OVF <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_dl_seq.sv
// Directed bench for rom_dl_seq: one GAP=0 instance (LEN=300), one GAP=3 instance (LEN=8).
// Checks ordering, pacing, checksum, overflow, restart and async reset.
module tb_rom_dl_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, svl0, srd0, dlen0, busy0, done0, ovf0;
  logic [7:0]  sdt0, dldt0;
  logic [17:0] dlad0;
  logic [15:0] csum0;
  logic        start1, svl1, srd1, dlen1, busy1, done1, ovf1;
  logic [7:0]  sdt1, dldt1;
  logic [17:0] dlad1;
  logic [15:0] csum1;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] d0 [300];
  logic [7:0] d1 [8];
  int sent0 = 0, exp0 = 0, nstb0 = 0;
  int sent1 = 0, exp1 = 0, nstb1 = 0;
  int last1 = -1;
  bit run1 = 0;
  bit sawfull = 0;
  int misses;
  bit first;
  int sum;

  always #5 clk = ~clk;

  rom_dl_seq #(.LEN(18'd300), .GAP(0)) u0 (
    .DLCL(clk), .RST_N(rst_n), .START(start0),
    .SDT(sdt0), .SVL(svl0), .SRD(srd0),
    .DLAD(dlad0), .DLDT(dldt0), .DLEN(dlen0),
    .BUSY(busy0), .DONE(done0), .OVF(ovf0), .CSUM(csum0)
  );

  rom_dl_seq #(.LEN(18'd8), .GAP(3)) u1 (
    .DLCL(clk), .RST_N(rst_n), .START(start1),
    .SDT(sdt1), .SVL(svl1), .SRD(srd1),
    .DLAD(dlad1), .DLDT(dldt1), .DLEN(dlen1),
    .BUSY(busy1), .DONE(done1), .OVF(ovf1), .CSUM(csum1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit x0, x1, s0, s1;
    x0 = svl0 && srd0 && busy0;
    x1 = svl1 && srd1 && busy1;
    s0 = start0;
    s1 = start1;
    @(posedge clk);
    #1;
    cyc++;
    if (s0) begin
      sent0 = 0; exp0 = 0; nstb0 = 0;
    end else begin
      if (x0) sent0++;
      if (dlen0) begin
        if (exp0 < 300) begin
          chk("d0_dlad", 32'(dlad0), 32'(exp0));
          chk("d0_dldt", 32'(dldt0), 32'(d0[exp0]));
        end
        exp0++;
        nstb0++;
      end
    end
    if (s1) begin
      sent1 = 0; exp1 = 0; nstb1 = 0; last1 = -1;
    end else begin
      if (x1) sent1++;
      if (dlen1) begin
        if (exp1 < 8) begin
          chk("d1_dlad", 32'(dlad1), 32'(exp1));
          chk("d1_dldt", 32'(dldt1), 32'(d1[exp1]));
        end
        if (run1 && last1 >= 0)
          chk("d1_spacing", 32'(cyc - last1), 32'd4);
        last1 = cyc;
        exp1++;
        nstb1++;
      end
      if (run1 && busy1 && !srd1)
        sawfull = 1;
    end
    sdt0 = (sent0 < 300) ? d0[sent0] : 8'h5a;
    sdt1 = (sent1 < 8) ? d1[sent1] : 8'h5a;
  endtask

  initial begin
    rst_n = 1'b0;
    start0 = 0; svl0 = 0; sdt0 = 0;
    start1 = 0; svl1 = 0; sdt1 = 0;
    for (int k = 0; k < 300; k++) d0[k] = 8'(k);
    for (int k = 0; k < 8; k++) d1[k] = 8'(8'hf0 + k);
    #3;
    chk("rst_dlen", 32'(dlen0), 0);
    chk("rst_dlad", 32'(dlad0), 0);
    chk("rst_dldt", 32'(dldt0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    chk("rst_csum", 32'(csum0), 0);
    svl0 = 1;
    #1;
    chk("rst_srd", 32'(srd0), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_srd", 32'(srd0), 0);
    chk("idle_busy", 32'(busy0), 0);
    chk("idle_sent", 32'(sent0), 0);

    // Full download, source always valid.
    start0 = 1;
    tick();
    start0 = 0;
    chk("t1_busy", 32'(busy0), 1);
    chk("t1_srd", 32'(srd0), 1);
    tick();
    chk("t1_lat0", 32'(dlen0), 0);
    tick();
    chk("t1_lat1", 32'(dlen0), 1);
    misses = 0;
    for (int i = 0; i < 1000 && !done0; i++) begin
      tick();
      if (!dlen0 && !done0) misses++;
    end
    chk("t1_done", 32'(done0), 1);
    chk("t1_busy_off", 32'(busy0), 0);
    chk("t1_misses", 32'(misses), 0);
    chk("t1_nstb", 32'(nstb0), 300);
    chk("t1_csum", 32'(csum0), 32'd33586);
    chk("t1_ovf0", 32'(ovf0), 0);
    chk("t1_srd_done", 32'(srd0), 1);
    tick();
    tick();
    svl0 = 0;
    tick();
    tick();
    chk("t1_ovf1", 32'(ovf0), 1);
    chk("t1_done2", 32'(done0), 1);
    chk("t1_nstb2", 32'(nstb0), 300);
    chk("t1_dlad_hold", 32'(dlad0), 299);
    chk("t1_dlen_off", 32'(dlen0), 0);

    // Restart in the middle of a load.
    start0 = 1;
    tick();
    start0 = 0;
    svl0 = 1;
    for (int i = 0; i < 500 && !(dlen0 && dlad0 == 18'd100); i++)
      tick();
    chk("t3_reach", 32'(dlad0), 100);
    start0 = 1;
    tick();
    start0 = 0;
    chk("t3_dlen", 32'(dlen0), 0);
    chk("t3_csum", 32'(csum0), 0);
    chk("t3_ovf", 32'(ovf0), 0);
    chk("t3_busy", 32'(busy0), 1);
    tick();
    tick();
    chk("t3_first", 32'(dlad0), 0);
    tick();
    tick();
    chk("t3_csum3", 32'(csum0), 3);
    for (int i = 0; i < 1000 && !done0; i++)
      tick();
    chk("t3_done", 32'(done0), 1);
    chk("t3_nstb", 32'(nstb0), 300);
    chk("t3_csum_end", 32'(csum0), 32'd33586);

    // Random source stalls.
    sum = 0;
    for (int k = 0; k < 300; k++) begin
      d0[k] = 8'(k * 37 + 5);
      sum += int'(d0[k]);
    end
    svl0 = 0;
    start0 = 1;
    tick();
    start0 = 0;
    for (int i = 0; i < 3000 && !done0; i++) begin
      svl0 = 1'($urandom_range(1, 0));
      tick();
    end
    svl0 = 0;
    chk("t2_done", 32'(done0), 1);
    chk("t2_nstb", 32'(nstb0), 300);
    chk("t2_csum", 32'(csum0), 32'(sum & 16'hffff));
    chk("t2_ovf", 32'(ovf0), 0);

    // Async reset mid-load.
    start0 = 1;
    tick();
    start0 = 0;
    svl0 = 1;
    for (int i = 0; i < 500 && !(dlen0 && dlad0 == 18'd50); i++)
      tick();
    chk("t4_reach", 32'(dlad0), 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_dlen", 32'(dlen0), 0);
    chk("t4_dlad", 32'(dlad0), 0);
    chk("t4_dldt", 32'(dldt0), 0);
    chk("t4_busy", 32'(busy0), 0);
    chk("t4_srd", 32'(srd0), 0);
    chk("t4_csum", 32'(csum0), 0);
    tick();
    rst_n = 1'b1;
    misses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dlen0 || busy0 || srd0) misses++;
    end
    chk("t4_idle", 32'(misses), 0);
    svl0 = 0;

    // Paced instance, GAP=3.
    run1 = 1;
    start1 = 1;
    tick();
    start1 = 0;
    svl1 = 1;
    for (int i = 0; i < 100 && !done1; i++)
      tick();
    svl1 = 0;
    chk("g_done", 32'(done1), 1);
    chk("g_nstb", 32'(nstb1), 8);
    chk("g_csum", 32'(csum1), 32'd1948);
    chk("g_full", 32'(sawfull), 1);
    chk("g_dlad", 32'(dlad1), 7);
    chk("g_dldt", 32'(dldt1), 32'hf7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
